// File: rtl/gray_counter_n_if.sv
// Control and observation bundle for gray_counter_n: step/load controls in,
// Gray/binary index and boundary indications out.
interface gray_counter_n_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             tc;
  logic             wrapped;

  modport master (
    output en, up, load, load_bin,
    input  gray, bin, tc, wrapped
  );

  modport slave (
    input  en, up, load, load_bin,
    output gray, bin, tc, wrapped
  );
endinterface

// File: rtl/gray_counter_n.sv
// WIDTH-bit up/down Gray-code counter with load, wrap-or-saturate ends, binary
// decode, terminal-count and one-cycle wrap pulse. Gray value is the flop state.
module gray_counter_n #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          WRAP      = 1'b1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic            clk,
  input  logic            reset,
  gray_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_IDX  = '1;
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic             wrapped_q;
  logic             wrapped_d;
  logic [WIDTH-1:0] bin_c;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR decode: bin[i] is the parity of gray[W-1:i].
  always_comb begin
    bin_c = gray_q;
    for (int unsigned s = 1; s < WIDTH; s++) begin
      bin_c = bin_c ^ (gray_q >> s);
    end
  end

  // Next-state selection in priority order load > step > hold.
  always_comb begin
    gray_d    = gray_q;
    wrapped_d = 1'b0;
    if (bus.load) begin
      gray_d = to_gray(bus.load_bin);
    end else if (bus.en) begin
      if (bus.up) begin
        if (bin_c != MAX_IDX) begin
          gray_d = to_gray(bin_c + WIDTH'(1));
        end else if (WRAP) begin
          gray_d    = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        if (bin_c != '0) begin
          gray_d = to_gray(bin_c - WIDTH'(1));
        end else if (WRAP) begin
          gray_d    = to_gray(MAX_IDX);
          wrapped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray_q    <= RST_GRAY;
      wrapped_q <= 1'b0;
    end else begin
      gray_q    <= gray_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.gray    = gray_q;
  assign bus.bin     = bin_c;
  assign bus.wrapped = wrapped_q;
  // Boundary look-ahead for the coming edge, independent of wrap mode.
  assign bus.tc      = bus.en & ~bus.load &
                       ((bus.up & (bin_c == MAX_IDX)) | (~bus.up & (bin_c == '0)));

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: three instances (3-bit wrap, 3-bit
// saturate with RESET_VAL=2, 8-bit wrap) driven by directed rows and a walk.
module tb_gray_counter_n;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_counter_n_if #(.WIDTH(3)) ia ();
  gray_counter_n_if #(.WIDTH(3)) ib ();
  gray_counter_n_if #(.WIDTH(8)) ic ();

  gray_counter_n #(.WIDTH(3), .WRAP(1'b1), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ia));
  gray_counter_n #(.WIDTH(3), .WRAP(1'b0), .RESET_VAL(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ib));
  gray_counter_n #(.WIDTH(8), .WRAP(1'b1), .RESET_VAL(0)) dut_c (
    .clk(clk), .reset(reset), .bus(ic));

  typedef struct {
    int         cyc;
    int         unit;
    int         row;
    logic [7:0] g;
    logic [7:0] b;
    logic       t;
    logic       w;
  } exp_t;

  typedef struct {
    logic       rst, en, up, ld;
    logic [2:0] lb, g, b;
    logic       t, w;
  } vec_t;

  exp_t q[$];
  exp_t e;
  logic [7:0] act_g, act_b;
  logic       act_t, act_w;
  logic [7:0] prev_c = '0;
  bit         c_active = 1'b0;

  // Unit A: 3-bit wrap. Fields: rst en up load load_bin | gray bin tc wrapped
  vec_t va [23] = '{
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b000,3'd0,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b001,3'd1,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b011,3'd2,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b010,3'd3,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b110,3'd4,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b111,3'd5,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b101,3'd6,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b100,3'd7,1'b1,1'b0},
    '{1'b1,1'b1,1'b0,1'b0,3'd0, 3'b000,3'd0,1'b1,1'b1},
    '{1'b1,1'b1,1'b0,1'b0,3'd0, 3'b100,3'd7,1'b0,1'b1},
    '{1'b1,1'b1,1'b0,1'b0,3'd0, 3'b101,3'd6,1'b0,1'b0},
    '{1'b1,1'b1,1'b0,1'b0,3'd0, 3'b111,3'd5,1'b0,1'b0},
    '{1'b1,1'b1,1'b0,1'b1,3'd5, 3'b110,3'd4,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b111,3'd5,1'b0,1'b0},
    '{1'b1,1'b0,1'b1,1'b0,3'd0, 3'b101,3'd6,1'b0,1'b0},
    '{1'b1,1'b0,1'b1,1'b0,3'd0, 3'b101,3'd6,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b1,3'd7, 3'b101,3'd6,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b100,3'd7,1'b1,1'b0},
    '{1'b1,1'b1,1'b1,1'b1,3'd0, 3'b000,3'd0,1'b0,1'b1},
    '{1'b1,1'b0,1'b0,1'b0,3'd0, 3'b000,3'd0,1'b0,1'b0},
    '{1'b1,1'b1,1'b0,1'b0,3'd0, 3'b000,3'd0,1'b1,1'b0},
    '{1'b1,1'b0,1'b0,1'b0,3'd0, 3'b100,3'd7,1'b0,1'b1},
    '{1'b1,1'b0,1'b0,1'b0,3'd0, 3'b100,3'd7,1'b0,1'b0}
  };

  // Unit B: 3-bit saturate, reset index 2; rows 15-16 hold reset low mid-count.
  vec_t vb [21] = '{
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b011,3'd2,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b010,3'd3,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b110,3'd4,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b111,3'd5,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b101,3'd6,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b100,3'd7,1'b1,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b100,3'd7,1'b1,1'b0},
    '{1'b1,1'b1,1'b0,1'b0,3'd0, 3'b100,3'd7,1'b0,1'b0},
    '{1'b1,1'b1,1'b0,1'b1,3'd1, 3'b101,3'd6,1'b0,1'b0},
    '{1'b1,1'b1,1'b0,1'b0,3'd0, 3'b001,3'd1,1'b0,1'b0},
    '{1'b1,1'b1,1'b0,1'b0,3'd0, 3'b000,3'd0,1'b1,1'b0},
    '{1'b1,1'b1,1'b0,1'b0,3'd0, 3'b000,3'd0,1'b1,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b000,3'd0,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b001,3'd1,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b011,3'd2,1'b0,1'b0},
    '{1'b0,1'b1,1'b1,1'b0,3'd0, 3'b011,3'd2,1'b0,1'b0},
    '{1'b0,1'b1,1'b1,1'b0,3'd0, 3'b011,3'd2,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b011,3'd2,1'b0,1'b0},
    '{1'b1,1'b1,1'b1,1'b0,3'd0, 3'b010,3'd3,1'b0,1'b0},
    '{1'b1,1'b0,1'b1,1'b0,3'd0, 3'b110,3'd4,1'b0,1'b0},
    '{1'b1,1'b0,1'b1,1'b0,3'd0, 3'b110,3'd4,1'b0,1'b0}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unit, input int row, input logic [7:0] g,
                      input logic [7:0] b, input logic t, input logic w);
    exp_t x;
    x.cyc = cyc; x.unit = unit; x.row = row;
    x.g = g; x.b = b; x.t = t; x.w = w;
    q.push_back(x);
  endtask

  // Drive one directed row mid-cycle and queue what the next negedge must show.
  task automatic apply(input int unit, input int row, input vec_t v);
    reset = v.rst;
    if (unit == 0) begin
      ia.en = v.en; ia.up = v.up; ia.load = v.ld; ia.load_bin = v.lb;
    end else begin
      ib.en = v.en; ib.up = v.up; ib.load = v.ld; ib.load_bin = v.lb;
    end
    push(unit, row, {5'd0, v.g}, {5'd0, v.b}, v.t, v.w);
  endtask

  function automatic logic [7:0] gray8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Monitor: compare every expectation due this cycle, plus single-bit steps on C.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.unit)
        0:       begin act_g = {5'd0, ia.gray}; act_b = {5'd0, ia.bin}; act_t = ia.tc; act_w = ia.wrapped; end
        1:       begin act_g = {5'd0, ib.gray}; act_b = {5'd0, ib.bin}; act_t = ib.tc; act_w = ib.wrapped; end
        default: begin act_g = ic.gray;         act_b = ic.bin;         act_t = ic.tc; act_w = ic.wrapped; end
      endcase
      n_vec++;
      if (e.cyc != cyc || act_g !== e.g || act_b !== e.b || act_t !== e.t || act_w !== e.w) begin
        n_bad++;
        $display("FAIL unit%0d row%0d cyc%0d: got gray=%h bin=%h tc=%b wrapped=%b, want gray=%h bin=%h tc=%b wrapped=%b",
                 e.unit, e.row, cyc, act_g, act_b, act_t, act_w, e.g, e.b, e.t, e.w);
      end
    end
    if (c_active) begin
      n_vec++;
      if ($countones(ic.gray ^ prev_c) > 1) begin
        n_bad++;
        $display("FAIL unit2 onehot cyc%0d: gray %h -> %h", cyc, prev_c, ic.gray);
      end
    end
    prev_c = ic.gray;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, %0d expectations pending", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   idx;
    logic wr;
    logic en_r, up_r;

    reset = 1'b0;
    ia.en = 1'b0; ia.up = 1'b0; ia.load = 1'b0; ia.load_bin = '0;
    ib.en = 1'b0; ib.up = 1'b0; ib.load = 1'b0; ib.load_bin = '0;
    ic.en = 1'b0; ic.up = 1'b0; ic.load = 1'b0; ic.load_bin = '0;

    tick();
    tick();
    push(0, -1, 8'h00, 8'h00, 1'b0, 1'b0);
    push(1, -1, 8'h03, 8'h02, 1'b0, 1'b0);
    push(2, -1, 8'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 23; i++) begin
      tick();
      apply(0, i, va[i]);
    end
    for (int i = 0; i < 21; i++) begin
      tick();
      apply(1, i, vb[i]);
    end
    tick();
    ib.en = 1'b0;

    // Unit C: reference walk over the 8-bit index with random enable/direction.
    idx = 0;
    wr  = 1'b0;
    c_active = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      tick();
      en_r = ($urandom_range(0, 3) != 0);
      up_r = 1'($urandom_range(0, 1));
      ic.en = en_r;
      ic.up = up_r;
      push(2, k, gray8(8'(idx)), 8'(idx),
           en_r && ((up_r && idx == 255) || (!up_r && idx == 0)), wr);
      wr = 1'b0;
      if (en_r) begin
        if (up_r) begin
          if (idx == 255) begin idx = 0; wr = 1'b1; end
          else idx = idx + 1;
        end else begin
          if (idx == 0) begin idx = 255; wr = 1'b1; end
          else idx = idx - 1;
        end
      end
    end
    tick();
    ic.en = 1'b0;
    tick();
    tick();

    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
